// File: rtl/pause_dim_ctrl.sv
// Pause merger and video dimmer for arcade cores. It combines the user toggle, the OSD
// pause and the request lines, and fades RGB after a long user pause.
module pause_dim_ctrl #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned DIM_SEC     = 10,
    parameter int unsigned STEP_CYCLES = 3000000,
    parameter int unsigned DIM_MAX     = 1,
    parameter int unsigned RW          = 3,
    parameter int unsigned GW          = 3,
    parameter int unsigned BW          = 2,
    parameter int unsigned NREQ        = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  btn_pause,
    input  logic                  osd_open,
    input  logic                  osd_pause_en,
    input  logic [NREQ-1:0]       req,
    input  logic [RW+GW+BW-1:0]   rgb_in,
    output logic                  pause,
    output logic                  user_paused,
    output logic [1:0]            dim_level,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    localparam int unsigned PW        = RW + GW + BW;
    localparam logic [63:0] DIM_CYC   = 64'(CLK_HZ) * 64'(DIM_SEC);
    localparam logic [31:0] DIM_LAST  = DIM_CYC[31:0] - 32'd1;
    localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES) - 32'd1;
    localparam logic [1:0]  LVL_MAX   = 2'(DIM_MAX);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FADE, S_DIM} state_t;

    state_t          state_q;
    logic [31:0]     cnt_q;
    logic [1:0]      dim_q;
    logic            btn_prev_q;
    logic            user_paused_q;
    logic            user_paused_d;
    logic            toggle;
    logic [PW-1:0]   rgb_q;
    logic [RW-1:0]   r_sh;
    logic [GW-1:0]   g_sh;
    logic [BW-1:0]   b_sh;

    always_comb begin
        toggle        = btn_pause & ~btn_prev_q;
        user_paused_d = user_paused_q ^ toggle;
    end

    // btn_prev resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            btn_prev_q    <= 1'b1;
            user_paused_q <= 1'b0;
        end else begin
            btn_prev_q    <= btn_pause;
            user_paused_q <= user_paused_d;
        end
    end

    // Pause edge restarts the timer; an unpause edge freezes everything for one cycle
    // (so a coincident step is dropped) before the next cycle clears back to idle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            dim_q   <= 2'd0;
        end else if (!user_paused_d && !user_paused_q) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            dim_q   <= 2'd0;
        end else if (user_paused_d) begin
            if (!user_paused_q) begin
                state_q <= S_WAIT;
                cnt_q   <= 32'd0;
                dim_q   <= 2'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_WAIT;
                        cnt_q   <= 32'd0;
                        dim_q   <= 2'd0;
                    end
                    S_WAIT: begin
                        if (cnt_q == DIM_LAST) begin
                            dim_q   <= 2'd1;
                            cnt_q   <= 32'd0;
                            state_q <= (LVL_MAX == 2'd1) ? S_DIM : S_FADE;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_FADE: begin
                        if (cnt_q == STEP_LAST) begin
                            dim_q <= dim_q + 2'd1;
                            cnt_q <= 32'd0;
                            if (dim_q + 2'd1 == LVL_MAX) begin
                                state_q <= S_DIM;
                            end
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_DIM: begin
                        dim_q <= LVL_MAX;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        r_sh = rgb_in[PW-1 -: RW] >> dim_q;
        g_sh = rgb_in[GW+BW-1 -: GW] >> dim_q;
        b_sh = rgb_in[BW-1:0] >> dim_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= {r_sh, g_sh, b_sh};
        end
    end

    assign pause       = user_paused_q | (osd_open & osd_pause_en) | (|req);
    assign user_paused = user_paused_q;
    assign dim_level   = dim_q;
    assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Self-checking bench for pause_dim_ctrl: table of pause vectors, timed fade sequences,
// and an rgb_out scoreboard fed with the expected dimmed pixel of every cycle.
module tb_pause_dim_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b1;
    logic       osd_open = 1'b0;
    logic       osd_en = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] rgb_in = 8'h00;
    logic       pause;
    logic       user_paused;
    logic [1:0] dim_level;
    logic [7:0] rgb_out;

    pause_dim_ctrl #(
        .CLK_HZ(100), .DIM_SEC(1), .STEP_CYCLES(10), .DIM_MAX(3),
        .RW(3), .GW(3), .BW(2), .NREQ(2)
    ) dut (
        .clk_sys(clk), .reset(rst), .btn_pause(btn), .osd_open(osd_open),
        .osd_pause_en(osd_en), .req(req), .rgb_in(rgb_in), .pause(pause),
        .user_paused(user_paused), .dim_level(dim_level), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       bprev = 1'b1;
    logic       exp_up = 1'b0;
    int         pcyc = 0;
    int         exp_dim = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic       oo;
        logic       oe;
        logic [1:0] rq;
        logic [7:0] rgb;
        logic       ep;
    } vec_t;
    vec_t vt[8];

    function automatic logic [7:0] shade(logic [7:0] p, int s);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = p[7:5] >> s;
        g = p[4:2] >> s;
        b = p[1:0] >> s;
        return {r, g, b};
    endfunction

    // Level k starts DIM_CYCLES + (k-1)*STEP_CYCLES cycles after the first paused cycle.
    function automatic int lvl(int p);
        int k;
        if (p < 100) return 0;
        k = 1 + (p - 100) / 10;
        return (k > 3) ? 3 : k;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic step();
        logic rise;
        logic was;
        sb_q.push_back(shade(rgb_in, exp_dim));
        rise   = btn & ~bprev;
        bprev  = btn;
        was    = exp_up;
        exp_up = exp_up ^ rise;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_up) begin
            pcyc    = was ? pcyc + 1 : 0;
            exp_dim = lvl(pcyc);
        end else if (!was) begin
            exp_dim = 0;
        end
        check("user_paused", int'(user_paused), int'(exp_up));
        check("dim_level", int'(dim_level), exp_dim);
        check("pause", int'(pause), int'(exp_up | (osd_open & osd_en) | (|req)));
        check("rgb_out", int'(rgb_out), int'(sb_q.pop_front()));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_steps(int n);
        for (int i = 0; i < n; i++) begin
            rgb_in = 8'($urandom);
            step();
        end
    endtask

    initial begin
        vt[0] = '{oo: 1'b1, oe: 1'b1, rq: 2'b00, rgb: 8'hFF, ep: 1'b1};
        vt[1] = '{oo: 1'b1, oe: 1'b0, rq: 2'b00, rgb: 8'hA5, ep: 1'b0};
        vt[2] = '{oo: 1'b0, oe: 1'b1, rq: 2'b00, rgb: 8'h5A, ep: 1'b0};
        vt[3] = '{oo: 1'b0, oe: 1'b0, rq: 2'b01, rgb: 8'h81, ep: 1'b1};
        vt[4] = '{oo: 1'b0, oe: 1'b0, rq: 2'b10, rgb: 8'h7E, ep: 1'b1};
        vt[5] = '{oo: 1'b1, oe: 1'b0, rq: 2'b11, rgb: 8'h3C, ep: 1'b1};
        vt[6] = '{oo: 1'b0, oe: 1'b0, rq: 2'b00, rgb: 8'hC3, ep: 1'b0};
        vt[7] = '{oo: 1'b1, oe: 1'b1, rq: 2'b10, rgb: 8'h18, ep: 1'b1};

        // Reset with the button held high
        #22 rst = 1'b0;
        #1;
        check("rst_user_paused", int'(user_paused), 0);
        check("rst_pause", int'(pause), 0);
        check("rst_dim", int'(dim_level), 0);
        check("rst_rgb", int'(rgb_out), 0);
        step();
        btn = 1'b0;
        step();
        $display("reset: held button caused no toggle, user_paused=%0d", user_paused);

        for (int i = 0; i < 8; i++) begin
            osd_open = vt[i].oo;
            osd_en   = vt[i].oe;
            req      = vt[i].rq;
            rgb_in   = vt[i].rgb;
            #1;
            check("pause_tbl", int'(pause), int'(vt[i].ep));
            step();
            $display("vector %0d: osd=%0b en=%0b req=%b rgb=%h pause=%0b", i,
                     vt[i].oo, vt[i].oe, vt[i].rq, vt[i].rgb, pause);
        end

        osd_open = 1'b0;
        osd_en   = 1'b0;
        req      = 2'b10;
        #1;
        check("req_zero_latency", int'(pause), 1);
        rand_steps(500);
        check("req_no_dim", int'(dim_level), 0);
        req      = 2'b00;
        osd_open = 1'b1;
        #1;
        check("osd_no_en", int'(pause), 0);
        osd_open = 1'b0;
        $display("request pause: 500 cycles without dimming");

        // Press at edge t, watch the full fade
        rgb_in = 8'hFF;
        btn = 1'b1;
        step();
        check("press_pause", int'(pause), 1);
        btn = 1'b0;
        steps(99);
        check("dim_before_l1", int'(dim_level), 0);
        step();
        check("dim_l1", int'(dim_level), 1);
        step();
        check("rgb_l1", int'(rgb_out), 8'h6D);
        steps(9);
        check("dim_l2", int'(dim_level), 2);
        step();
        check("rgb_l2", int'(rgb_out), 8'h24);
        steps(9);
        check("dim_l3", int'(dim_level), 3);
        step();
        check("rgb_l3", int'(rgb_out), 8'h00);
        rand_steps(200);
        check("dim_hold", int'(dim_level), 3);
        $display("fade: levels 1,2,3 reached, held for 200 cycles");

        btn = 1'b1;
        step();
        check("unpause_up", int'(user_paused), 0);
        check("unpause_dim_lag", int'(dim_level), 3);
        btn = 1'b0;
        step();
        check("unpause_dim", int'(dim_level), 0);
        rand_steps(20);
        $display("unpause from DIM: rgb passes through undimmed");

        // Unpause edge coincides with the WAIT boundary
        btn = 1'b1;
        step();
        btn = 1'b0;
        steps(99);
        btn = 1'b1;
        step();
        check("bnd_up", int'(user_paused), 0);
        check("bnd_dim", int'(dim_level), 0);
        btn = 1'b0;
        rand_steps(150);
        check("bnd_dim_stays", int'(dim_level), 0);
        $display("boundary unpause: no step taken");

        btn = 1'b1;
        step();
        btn = 1'b0;
        steps(99);
        check("repause_l0", int'(dim_level), 0);
        step();
        check("repause_l1", int'(dim_level), 1);
        steps(15);
        check("pre_reset_l2", int'(dim_level), 2);
        $display("re-pause: timer restarted, level 2 in fade");

        rst = 1'b1;
        #1;
        check("async_dim", int'(dim_level), 0);
        check("async_up", int'(user_paused), 0);
        check("async_rgb", int'(rgb_out), 0);
        #3 rst = 1'b0;
        bprev   = 1'b1;
        exp_up  = 1'b0;
        exp_dim = 0;
        pcyc    = 0;
        sb_q.delete();
        rand_steps(5);
        $display("async reset: registers cleared before the next edge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
